// File: rtl/window_sum_detector.sv
// ---------------------------------------------------------------------------
// window_sum_detector
//
// Watches the moving-window sum coming out of the 5-tap sample filter and
// turns sustained excursions into discrete events:
//   - entry needs DEBOUNCE consecutive valid samples at or above HI_THR
//   - an event ends on the first valid sample below LO_THR (hysteresis band
//     between LO_THR and HI_THR keeps the event alive)
//   - after release the detector is deaf for a hold-off period
// For each event it reports the start, the peak sum seen while the event was
// running, and a saturating count of events.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   sum_in       window sum from the filter stage (SUM_W bits, unsigned)
//   sum_valid    sum_in is valid this cycle
//   clear_stats  zero event_count on the next clock
//   active       high while an event is in progress
//   event_pulse  one-cycle pulse when an event starts
//   peak_valid   one-cycle pulse when peak_value is refreshed at release
//   peak_value   largest sum_in of the most recently completed event
//   event_count  number of events detected, sticks at all-ones
// ---------------------------------------------------------------------------
module window_sum_detector #(
  parameter int SUM_W    = 12,
  parameter int HI_THR   = 640,
  parameter int LO_THR   = 384,
  parameter int DEBOUNCE = 3,
  parameter int HOLDOFF  = 8,
  parameter int EVT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  input  logic             clear_stats,
  output logic             active,
  output logic             event_pulse,
  output logic             peak_valid,
  output logic [SUM_W-1:0] peak_value,
  output logic [EVT_W-1:0] event_count
);

  // Counters are sized so that the terminal value itself is representable.
  localparam int DEB_W  = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic [SUM_W-1:0]  HI_VAL   = SUM_W'(HI_THR);
  localparam logic [SUM_W-1:0]  LO_VAL   = SUM_W'(LO_THR);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLDOFF);
  localparam logic [EVT_W-1:0]  EVT_MAX  = {EVT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_ACTIVE,
    ST_HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SUM_W-1:0]  run_peak_q, run_peak_d;
  logic              active_q, active_d;
  logic              event_pulse_q, event_pulse_d;
  logic              peak_valid_q, peak_valid_d;
  logic [SUM_W-1:0]  peak_value_q, peak_value_d;
  logic [EVT_W-1:0]  event_count_q, event_count_d;

  logic              hi_hit;
  logic              enter_active;
  logic [SUM_W-1:0]  peak_with_sample;

  assign hi_hit           = sum_valid && (sum_in >= HI_VAL);
  assign peak_with_sample = (sum_in > run_peak_q) ? sum_in : run_peak_q;

  // Next-state and output computation. Every registered output is derived
  // from the next state so the ports change on the edge that captures the
  // deciding sample.
  always_comb begin
    state_d       = state_q;
    deb_d         = deb_q;
    hold_d        = hold_q;
    run_peak_d    = run_peak_q;
    peak_value_d  = peak_value_q;
    event_count_d = event_count_q;
    event_pulse_d = 1'b0;
    peak_valid_d  = 1'b0;
    enter_active  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hi_hit) begin
          // The first qualifying sample seeds the running peak.
          run_peak_d = sum_in;
          if (DEBOUNCE <= 1) begin
            enter_active = 1'b1;
          end else begin
            state_d = ST_ARMING;
            deb_d   = DEB_W'(1);
          end
        end
      end

      ST_ARMING: begin
        if (sum_valid) begin
          if (sum_in >= HI_VAL) begin
            run_peak_d = peak_with_sample;
            if (deb_q + DEB_W'(1) >= DEB_LAST) begin
              enter_active = 1'b1;
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            // A single dip below HI_THR breaks the debounce run.
            state_d = ST_IDLE;
            deb_d   = '0;
          end
        end
      end

      ST_ACTIVE: begin
        if (sum_valid) begin
          if (sum_in < LO_VAL) begin
            // The releasing sample is deliberately left out of the peak.
            peak_value_d = run_peak_q;
            peak_valid_d = 1'b1;
            if (HOLDOFF == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              hold_d  = HOLD_LD;
            end
          end else begin
            run_peak_d = peak_with_sample;
          end
        end
      end

      ST_HOLDOFF: begin
        // Counts clocks, not samples; inputs are ignored until IDLE.
        if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_active) begin
      state_d       = ST_ACTIVE;
      deb_d         = '0;
      event_pulse_d = 1'b1;
    end

    // A clear that lands on the same edge as a new event still counts that
    // event, so the result is 1 rather than 0.
    if (clear_stats) begin
      event_count_d = enter_active ? EVT_W'(1) : '0;
    end else if (enter_active && (event_count_q != EVT_MAX)) begin
      event_count_d = event_count_q + EVT_W'(1);
    end

    active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers. Reset drops any event in flight without
  // reporting a peak.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      deb_q         <= '0;
      hold_q        <= '0;
      run_peak_q    <= '0;
      active_q      <= 1'b0;
      event_pulse_q <= 1'b0;
      peak_valid_q  <= 1'b0;
      peak_value_q  <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      hold_q        <= hold_d;
      run_peak_q    <= run_peak_d;
      active_q      <= active_d;
      event_pulse_q <= event_pulse_d;
      peak_valid_q  <= peak_valid_d;
      peak_value_q  <= peak_value_d;
      event_count_q <= event_count_d;
    end
  end

  assign active      = active_q;
  assign event_pulse = event_pulse_q;
  assign peak_valid  = peak_valid_q;
  assign peak_value  = peak_value_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_window_sum_detector.sv
// ---------------------------------------------------------------------------
// tb_window_sum_detector
//
// Directed bench for window_sum_detector. Two instances share all inputs:
// dut uses the default parameters, dut_sat narrows event_count to 2 bits so
// saturation is reachable in a handful of events. Every expected value below
// is worked out by hand from the detector's intended timing.
// ---------------------------------------------------------------------------
module tb_window_sum_detector;

  logic        clk;
  logic        reset;
  logic [11:0] sum_in;
  logic        sum_valid;
  logic        clear_stats;

  logic        active,      active_s;
  logic        event_pulse, event_pulse_s;
  logic        peak_valid,  peak_valid_s;
  logic [11:0] peak_value,  peak_value_s;
  logic [15:0] event_count;
  logic [1:0]  event_count_s;

  int assertCount;
  int failCount;

  window_sum_detector dut (
    .clk         (clk),
    .reset       (reset),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .clear_stats (clear_stats),
    .active      (active),
    .event_pulse (event_pulse),
    .peak_valid  (peak_valid),
    .peak_value  (peak_value),
    .event_count (event_count)
  );

  window_sum_detector #(.EVT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .clear_stats (clear_stats),
    .active      (active_s),
    .event_pulse (event_pulse_s),
    .peak_valid  (peak_valid_s),
    .peak_value  (peak_value_s),
    .event_count (event_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then returns just after
  // the rising edge that captured them.
  task automatic applyStimulus(input logic valid, input logic [11:0] sum,
                               input logic clr);
    @(negedge clk);
    sum_valid   = valid;
    sum_in      = sum;
    clear_stats = clr;
    @(posedge clk);
    #1;
  endtask

  // One complete event: three qualifying samples, a release, hold-off idle.
  task automatic runEvent(input int expCount, input int expCountSat);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("evt_no_early_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("evt_pulse", event_pulse, 1);
    checkOutput("evt_count", event_count, expCount);
    checkOutput("evt_count_sat", event_count_s, expCountSat);
    applyStimulus(1'b1, 12'd300, 1'b0);
    checkOutput("evt_peak_valid", peak_valid, 1);
    checkOutput("evt_peak_value", peak_value, 700);
    repeat (9) applyStimulus(1'b0, 12'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    sum_in      = '0;
    sum_valid   = 1'b0;
    clear_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_active", active, 0);
    checkOutput("rst_pulse", event_pulse, 0);
    checkOutput("rst_peak_valid", peak_valid, 0);
    checkOutput("rst_peak_value", peak_value, 0);
    checkOutput("rst_count", event_count, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] debounced entry");
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t1_s1_pulse", event_pulse, 0);
    checkOutput("t1_s1_active", active, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t1_s2_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t1_pulse", event_pulse, 1);
    checkOutput("t1_active", active, 1);
    checkOutput("t1_count", event_count, 1);
    applyStimulus(1'b0, 12'd0, 1'b0);
    checkOutput("t1_pulse_one_cycle", event_pulse, 0);
    checkOutput("t1_active_hold", active, 1);

    $display("[TB] hysteresis band holds the event");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 12'd500, 1'b0);
      checkOutput("t4_active", active, 1);
      checkOutput("t4_no_peak_valid", peak_valid, 0);
    end

    $display("[TB] peak capture and hold-off");
    applyStimulus(1'b1, 12'd900, 1'b0);
    applyStimulus(1'b1, 12'd800, 1'b0);
    applyStimulus(1'b1, 12'd384, 1'b0);
    checkOutput("t3_lo_boundary_stays", active, 1);
    applyStimulus(1'b1, 12'd300, 1'b0);
    checkOutput("t3_peak_valid", peak_valid, 1);
    checkOutput("t3_peak_value", peak_value, 900);
    checkOutput("t3_active_off", active, 0);
    checkOutput("t3_pulse_off", event_pulse, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 12'd900, 1'b0);
      checkOutput("t3_holdoff_active", active, 0);
      checkOutput("t3_holdoff_pulse", event_pulse, 0);
      checkOutput("t3_holdoff_peak_valid", peak_valid, 0);
    end
    checkOutput("t3_peak_held", peak_value, 900);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t3_retrig_not_early", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t3_retrig_pulse", event_pulse, 1);
    checkOutput("t3_retrig_count", event_count, 2);
    applyStimulus(1'b1, 12'd383, 1'b0);
    checkOutput("t3_lo_boundary_release", peak_valid, 1);
    checkOutput("t3_second_peak", peak_value, 700);
    repeat (9) applyStimulus(1'b0, 12'd0, 1'b0);

    $display("[TB] aborted arming");
    applyStimulus(1'b1, 12'd640, 1'b0);
    checkOutput("t2_s1_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t2_s2_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd100, 1'b0);
    checkOutput("t2_abort_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b1, 12'd639, 1'b0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t2_hi_boundary_pulse", event_pulse, 0);
    checkOutput("t2_count", event_count, 2);
    applyStimulus(1'b1, 12'd100, 1'b0);

    $display("[TB] gaps in sum_valid and reset mid-event");
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b0);
    checkOutput("t5_gap1_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b0);
    checkOutput("t5_gap2_pulse", event_pulse, 0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    checkOutput("t5_pulse", event_pulse, 1);
    checkOutput("t5_count", event_count, 3);
    checkOutput("t5_count_sat", event_count_s, 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_active", active, 0);
    checkOutput("t5_rst_peak_valid", peak_valid, 0);
    checkOutput("t5_rst_peak_value", peak_value, 0);
    checkOutput("t5_rst_count", event_count, 0);
    checkOutput("t5_rst_count_sat", event_count_s, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 12'd300, 1'b0);
    checkOutput("t5_after_rst_peak_valid", peak_valid, 0);
    checkOutput("t5_after_rst_active", active, 0);

    $display("[TB] counter saturation and clear");
    runEvent(1, 1);
    runEvent(2, 2);
    runEvent(3, 3);
    runEvent(4, 3);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b1, 12'd700, 1'b0);
    applyStimulus(1'b1, 12'd700, 1'b1);
    checkOutput("t6_clear_with_evt_pulse", event_pulse, 1);
    checkOutput("t6_clear_with_evt", event_count, 1);
    checkOutput("t6_clear_with_evt_sat", event_count_s, 1);
    applyStimulus(1'b1, 12'd300, 1'b1);
    checkOutput("t6_clear_alone", event_count, 0);
    checkOutput("t6_clear_alone_sat", event_count_s, 0);
    checkOutput("t6_release_sat", peak_valid_s, 1);
    checkOutput("t6_peak_sat", peak_value_s, 700);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
